// File: rtl/edge_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter_pkg
// Description : Shared constants, encodings and round-robin pick helper for
//               the four-channel edge event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_event_arbiter_pkg;

    localparam int NCH = 4;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_OFFER = 1'b1;

    localparam logic c_MODE_RR    = 1'b0;
    localparam logic c_MODE_FIXED = 1'b1;

    // Tile pin map
    localparam int c_IN_CLK       = 0;
    localparam int c_IN_RST       = 1;
    localparam int c_IN_EV_LO     = 2;
    localparam int c_IN_ACK       = 6;
    localparam int c_IN_MODE      = 7;
    localparam int c_OUT_VALID    = 0;
    localparam int c_OUT_GRANT_LO = 1;
    localparam int c_OUT_OVF      = 3;
    localparam int c_OUT_PEND_LO  = 4;

    // First requesting channel at or above start, wrapping; fixed priority
    // is the same search with start = 0.
    function automatic logic [1:0] f_pick(input logic [NCH-1:0] req,
                                          input logic [1:0]     start);
        logic [1:0] idx;
        logic       found;
        f_pick = start;
        found  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = start + 2'(i);
            if (!found && req[idx]) begin
                f_pick = idx;
                found  = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter_if
// Description : Event inputs, ack/mode and offer outputs of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface edge_event_arbiter_if;
    import edge_event_arbiter_pkg::*;

    logic [NCH-1:0] events;
    logic           ack;
    logic           mode;
    logic           valid;
    logic [1:0]     grant;
    logic           overflow;
    logic [NCH-1:0] pending;

    modport master (output events, ack, mode,
                    input  valid, grant, overflow, pending);
    modport slave  (input  events, ack, mode,
                    output valid, grant, overflow, pending);
endinterface
`default_nettype wire

// File: rtl/edge_event_arbiter_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter_sync_edge_detect
// Description : Multi-flop synchronizer plus previous-value flop giving a
//               one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_din,
    output logic      o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Four-channel rising-edge event collector with round-robin /
//               fixed-priority arbitration and a valid/ack offer handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    edge_event_arbiter_if.slave  bus
);

    logic [NCH-1:0]         w_edge;
    logic                   w_ack_rise;
    logic [SYNC_STAGES-1:0] r_mode_sync;
    logic                   w_mode;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [1:0]             r_grant;
    logic [1:0]             r_rr_ptr;
    logic [1:0]             w_winner;
    logic [NCH-1:0]         r_pending;
    logic [NCH-1:0]         w_clear;
    logic                   w_ack_take;
    logic                   r_overflow;

    generate
        for (genvar n = 0; n < NCH; n++) begin : g_ch
            edge_event_arbiter_sync_edge_detect #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge_detect (
                .clk    (clk),
                .rst    (rst),
                .i_din  (bus.events[n]),
                .o_edge (w_edge[n])
            );
        end
    endgenerate

    edge_event_arbiter_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_edge_detect (
        .clk    (clk),
        .rst    (rst),
        .i_din  (bus.ack),
        .o_edge (w_ack_rise)
    );

    // Mode is a level, so it only needs the synchronizer, not edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mode_sync <= '0;
        else     r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], bus.mode};
    end
    assign w_mode = r_mode_sync[SYNC_STAGES-1];

    assign w_winner   = f_pick(r_pending, (w_mode == c_MODE_FIXED) ? 2'd0 : r_rr_ptr);
    assign w_ack_take = (r_state == c_OFFER) && w_ack_rise;

    always_comb begin
        w_clear = '0;
        if (w_ack_take) w_clear[r_grant] = 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (|r_pending) w_state_nxt = c_OFFER;
            c_OFFER: if (w_ack_take) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.valid = (r_state == c_OFFER);
    end

    // A new edge coinciding with its own clear is queued, not counted as lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_grant    <= 2'd0;
            r_rr_ptr   <= 2'd0;
        end else begin
            r_pending  <= (r_pending & ~w_clear) | w_edge;
            r_overflow <= r_overflow | (|(w_edge & r_pending & ~w_clear));
            if ((r_state == c_IDLE) && (|r_pending)) r_grant <= w_winner;
            if (w_ack_take) r_rr_ptr <= r_grant + 2'd1;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.pending  = r_pending;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
